// File: rtl/plot_arbiter_pkg.sv
// Shared definitions for the plot arbiter: requester indices, widths,
// the arbiter state type and the pixel payload.
package plot_arbiter_pkg;

    localparam int unsigned NUM_REQ  = 3;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned PTR_W    = 2;

    localparam logic [PTR_W-1:0] REQ_BG  = 2'd0;
    localparam logic [PTR_W-1:0] REQ_CAR = 2'd1;
    localparam logic [PTR_W-1:0] REQ_OBS = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // Index of the set bit of a one-hot vector (0 when none is set).
    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
        onehot_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) onehot_idx = PTR_W'(i);
        end
    endfunction

endpackage

// File: rtl/plot_arbiter_rr_select3.sv
// rr_select3: round-robin winner pick among 3 requesters.
// Ports: req_i   - request bits
//        ptr_i   - last served requester; search starts at ptr_i+1
//        winner_c - one-hot winner (combinational), zero when no request
module rr_select3
    import plot_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_c
);

    // Walk ptr+1, ptr+2, ptr+3 (mod 3); first requester found wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner_c = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_c = NUM_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter feeding three pixel sources into one
// vga_adapter write port, with an optional background scroll offset.
// Optional feature: define PLOT_ARBITER_SCROLL_EN to enable the scroll offset.
// Ports: CLOCK_50/reset (sync, active-high); req/last/req_x/req_y/req_colour
//        per-requester pixel stream; scroll_step pulse; grant (registered),
//        ack (combinational); VGA_X/VGA_Y/VGA_COLOR/plot registered pixel
//        write; scroll_offset current background line offset.
module plot_arbiter
    import plot_arbiter_pkg::*;
#(
    parameter int unsigned XSCREEN = 160,
    parameter int unsigned YSCREEN = 120
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*X_W-1:0]        req_x,
    input  logic [NUM_REQ*Y_W-1:0]        req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]   req_colour,
    input  logic                          scroll_step,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic [X_W-1:0]                VGA_X,
    output logic [Y_W-1:0]                VGA_Y,
    output logic [COLOUR_W-1:0]           VGA_COLOR,
    output logic                          plot,
    output logic [Y_W-1:0]                scroll_offset
);

    arb_state_e          state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [PTR_W-1:0]    ptr_q;
    pixel_t              pix_q;
    logic                plot_q;

    logic [PTR_W-1:0]    gidx_c;
    pixel_t              pix_sel_c;
    logic [Y_W-1:0]      y_out_c;
    logic                in_range_c;
    logic                release_c;
    logic [NUM_REQ-1:0]  rr_req_c;
    logic [PTR_W-1:0]    rr_ptr_c;
    logic [NUM_REQ-1:0]  winner_c;

`ifdef PLOT_ARBITER_SCROLL_EN
    logic [Y_W-1:0]      offset_q;
    logic                pending_q;
    logic [Y_W:0]        y_sum_c;
    logic                hold_bg_c;
    logic                step_c;
`endif

    assign ack           = grant_q & req;
    assign grant         = grant_q;
    assign VGA_X         = pix_q.x;
    assign VGA_Y         = pix_q.y;
    assign VGA_COLOR     = pix_q.colour;
    assign plot          = plot_q;

    // Granted requester's pixel and its range check (on the raw y).
    assign gidx_c           = onehot_idx(grant_q);
    assign pix_sel_c.x      = req_x[X_W*gidx_c +: X_W];
    assign pix_sel_c.y      = req_y[Y_W*gidx_c +: Y_W];
    assign pix_sel_c.colour = req_colour[COLOUR_W*gidx_c +: COLOUR_W];
    assign in_range_c       = (32'(pix_sel_c.x) < XSCREEN) && (32'(pix_sel_c.y) < YSCREEN);

    // Release after ack&last, or when the granted request drops.
    assign release_c = |(grant_q & (~req | last));

    // On release only the other requesters compete, searching past the holder.
    assign rr_req_c = (state_q == ST_IDLE) ? req : (req & ~grant_q);
    assign rr_ptr_c = (state_q == ST_IDLE) ? ptr_q : gidx_c;

    rr_select3 u_rr (
        .req_i    (rr_req_c),
        .ptr_i    (rr_ptr_c),
        .winner_c (winner_c)
    );

`ifdef PLOT_ARBITER_SCROLL_EN
    // Background y wraps by subtraction; 8-bit sum holds y+offset.
    always_comb begin
        y_sum_c = (Y_W+1)'(pix_sel_c.y) + (Y_W+1)'(offset_q);
        y_out_c = pix_sel_c.y;
        if (gidx_c == REQ_BG) begin
            if (y_sum_c >= (Y_W+1)'(YSCREEN)) y_out_c = Y_W'(y_sum_c - (Y_W+1)'(YSCREEN));
            else                              y_out_c = Y_W'(y_sum_c);
        end
    end

    // A step is deferred while the background holds grant so a burst sees one offset.
    assign hold_bg_c = grant_q[REQ_BG] & ~release_c;
    assign step_c    = pending_q | scroll_step;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            offset_q  <= '0;
            pending_q <= 1'b0;
        end else if (hold_bg_c) begin
            pending_q <= step_c;
        end else begin
            pending_q <= 1'b0;
            if (step_c) begin
                offset_q <= (offset_q == Y_W'(YSCREEN-1)) ? '0 : offset_q + Y_W'(1);
            end
        end
    end

    assign scroll_offset = offset_q;
`else
    logic unused_scroll;
    assign unused_scroll = scroll_step;
    assign y_out_c       = pix_sel_c.y;
    assign scroll_offset = '0;
`endif

    // Arbiter FSM and registered pixel output.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= REQ_BG;
            pix_q   <= '0;
            plot_q  <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            if (|ack) begin
                plot_q       <= in_range_c;
                pix_q.x      <= pix_sel_c.x;
                pix_q.y      <= y_out_c;
                pix_q.colour <= pix_sel_c.colour;
            end
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= winner_c;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (release_c) begin
                        ptr_q   <= gidx_c;
                        grant_q <= winner_c;
                        state_q <= (|winner_c) ? ST_BUSY : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_arbiter.sv
// Randomized and directed bench for plot_arbiter against a behavioural model.
module tb_plot_arbiter;

    localparam int XS = 160;
    localparam int YS = 120;
`ifdef PLOT_ARBITER_SCROLL_EN
    localparam bit SCROLL = 1'b1;
`else
    localparam bit SCROLL = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [2:0]  req, last;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic        scroll_step;
    logic [2:0]  grant, ack;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_COLOR;
    logic        plot;
    logic [6:0]  scroll_offset;

    plot_arbiter dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .req           (req),
        .last          (last),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_colour    (req_colour),
        .scroll_step   (scroll_step),
        .grant         (grant),
        .ack           (ack),
        .VGA_X         (VGA_X),
        .VGA_Y         (VGA_Y),
        .VGA_COLOR     (VGA_COLOR),
        .plot          (plot),
        .scroll_offset (scroll_offset)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Stimulus state: pixels left per requester and the pixel each presents.
    int         rem [3];
    logic [7:0] px [3];
    logic [6:0] py [3];
    logic [2:0] pc [3];
    bit         hold_rem;
    logic [2:0] last_ack;

    // Behavioural model: granted requester (-1 none), last released, scroll.
    int         m_g, m_ptr, m_off, m_acked;
    bit         m_pend, m_plot;
    int         m_x, m_y, m_c;

    function automatic int rr_pick(input logic [2:0] r, input int base, input int n);
        for (int k = 1; k <= n; k++) begin
            if (r[(base + k) % 3]) return (base + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit rel, st;
        m_acked = -1;
        m_plot  = 1'b0;
        if (reset) begin
            m_g = -1; m_ptr = 0; m_off = 0; m_pend = 1'b0;
            m_x = 0; m_y = 0; m_c = 0;
            return;
        end
        if (m_g >= 0 && req[m_g]) begin
            m_acked = m_g;
            m_plot  = (int'(px[m_g]) < XS) && (int'(py[m_g]) < YS);
            m_x     = int'(px[m_g]);
            m_c     = int'(pc[m_g]);
            m_y     = (SCROLL && m_g == 0) ? (int'(py[m_g]) + m_off) % YS : int'(py[m_g]);
        end
        rel = (m_g >= 0) && (!req[m_g] || last[m_g]);
        if (SCROLL) begin
            st = m_pend || scroll_step;
            if (m_g == 0 && !rel) m_pend = st;
            else begin
                if (st) m_off = (m_off + 1) % YS;
                m_pend = 1'b0;
            end
        end
        if (m_g < 0) begin
            if (req != 3'b000) m_g = rr_pick(req, m_ptr, 3);
        end else if (rel) begin
            m_ptr = m_g;
            m_g   = rr_pick(req, m_g, 2);
        end
    endtask

    // One clock: drive, check ack, clock edge, check registered outputs.
    task automatic tick(input bit rnd);
        logic [2:0] r, l, ea;
        for (int i = 0; i < 3; i++) begin
            r[i] = rem[i] > 0;
            l[i] = rem[i] == 1;
            if (rnd) begin
                if ($urandom_range(15, 0) == 0) r[i] = 1'b0;
                px[i] = 8'($urandom_range(170, 0));
                py[i] = 7'($urandom_range(125, 0));
                pc[i] = 3'($urandom_range(7, 0));
            end
        end
        req        = r;
        last       = l;
        req_x      = {px[2], px[1], px[0]};
        req_y      = {py[2], py[1], py[0]};
        req_colour = {pc[2], pc[1], pc[0]};
        #1;
        ea = (m_g >= 0) ? (req & (3'b001 << m_g)) : 3'b000;
        last_ack = ack;
        check("ack", ack, ea);
        @(posedge CLOCK_50);
        model_step();
        #1;
        if (m_acked >= 0 && rem[m_acked] > 0 && !hold_rem) rem[m_acked]--;
        check("grant", grant, (m_g >= 0) ? (3'b001 << m_g) : 3'b000);
        check("plot", plot, m_plot);
        check("scroll_offset", scroll_offset, m_off);
        if (m_plot) begin
            check("vga_x", VGA_X, m_x);
            check("vga_y", VGA_Y, m_y);
            check("vga_colour", VGA_COLOR, m_c);
        end
    endtask

    initial begin
        logic [2:0] seq [4];
        int nplot;
        seq[0] = 3'b010; seq[1] = 3'b100; seq[2] = 3'b001; seq[3] = 3'b010;
        reset = 1'b1; scroll_step = 1'b0; hold_rem = 1'b0;
        req = '0; last = '0; req_x = '0; req_y = '0; req_colour = '0;
        m_g = -1; m_ptr = 0; m_off = 0; m_pend = 1'b0; m_acked = -1; m_plot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; px[i] = 8'(10 + 20 * i); py[i] = 7'd5; pc[i] = 3'(i + 1);
        end
        @(posedge CLOCK_50); model_step(); #1;
        tick(0);
        check("rst_vga_x", VGA_X, 0);
        check("rst_vga_y", VGA_Y, 0);
        check("rst_vga_c", VGA_COLOR, 0);
        reset = 1'b0;

        // 4-pixel background burst.
        rem[0] = 4;
        tick(0);
        check("bg_grant", grant, 3'b001);
        nplot = 0;
        for (int k = 0; k < 6; k++) begin
            tick(0);
            if (plot) nplot++;
        end
        check("bg_nplot", nplot, 4);
        check("bg_released", grant, 3'b000);

        // All three requesting with single-pixel bursts.
        hold_rem = 1'b1;
        rem[0] = 1; rem[1] = 1; rem[2] = 1;
        for (int k = 0; k < 4; k++) begin
            tick(0);
            check("rr_seq", grant, seq[k]);
        end
        hold_rem = 1'b0;
        rem[0] = 0; rem[1] = 0; rem[2] = 0;
        repeat (3) tick(0);

`ifdef PLOT_ARBITER_SCROLL_EN
        // Offset wrap and background y adjust.
        scroll_step = 1'b1;
        repeat (119) tick(0);
        check("off_119", scroll_offset, 119);
        tick(0);
        check("off_wrap", scroll_offset, 0);
        scroll_step = 1'b0;
        rem[0] = 1;
        repeat (2) tick(0);
        check("bg_y_off0", VGA_Y, 5);
        tick(0);
        scroll_step = 1'b1;
        repeat (118) tick(0);
        scroll_step = 1'b0;
        rem[0] = 1;
        repeat (2) tick(0);
        check("bg_y_off118", VGA_Y, 3);
        tick(0);

        // Steps during a 3-pixel background burst.
        rem[0] = 3;
        tick(0);
        scroll_step = 1'b1;
        tick(0);
        check("burst_y1", VGA_Y, 3);
        tick(0);
        scroll_step = 1'b0;
        check("burst_y2", VGA_Y, 3);
        check("burst_off_held", scroll_offset, 118);
        tick(0);
        check("burst_y3", VGA_Y, 3);
        check("burst_off_inc", scroll_offset, 119);
        repeat (2) tick(0);
        check("burst_off_once", scroll_offset, 119);
`endif

        // Car pixel off-screen, then reset in the middle of a burst.
        px[1] = 8'd160;
        rem[1] = 1;
        repeat (2) tick(0);
        check("car_ack", last_ack, 3'b010);
        check("car_plot", plot, 1'b0);
        px[1] = 8'd30;
        rem[2] = 4;
        repeat (2) tick(0);
        reset = 1'b1;
        tick(0);
        check("mid_rst_grant", grant, 3'b000);
        check("mid_rst_plot", plot, 1'b0);
        reset = 1'b0;
        rem[2] = 0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0 && $urandom_range(5, 0) == 0) rem[i] = $urandom_range(5, 1);
            end
            scroll_step = ($urandom_range(9, 0) == 0);
            reset       = ($urandom_range(499, 0) == 0);
            tick(1);
        end
        reset = 1'b0;
        scroll_step = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
